// File: rtl/reco_pkg.sv
// -----------------------------------------------------------------------------
// reco_pkg
//   Shared definitions for the recommendation dot-product stage.
//   - Default parameter values for the stage (widths, lanes, vector length)
//   - BEATS / PROD_W derived from those defaults
//   - Helper functions to derive beat count, product width and beat-counter
//     width from arbitrary parameter values
//   - A sign-extension helper used by the adder tree
// -----------------------------------------------------------------------------
package reco_pkg;

    localparam int BITWIDTH_DEF       = 32;
    localparam int INPUT_BITWIDTH_DEF = 16;
    localparam int LANES_DEF          = 4;
    localparam int VEC_LEN_DEF        = 16;

    // Beats per vector and full-precision product width for the defaults.
    localparam int BEATS  = VEC_LEN_DEF / LANES_DEF;
    localparam int PROD_W = 2 * INPUT_BITWIDTH_DEF;

    // Working width of the sign-extension helper. Products and results are
    // assumed to fit in this many bits.
    localparam int SEXT_W = 64;

    function automatic int beats_of(input int vec_len, input int lanes);
        return vec_len / lanes;
    endfunction

    function automatic int prod_w_of(input int in_w);
        return 2 * in_w;
    endfunction

    // A single-beat vector still needs a one-bit counter so the port widths
    // never collapse to zero.
    function automatic int cnt_w_of(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Replicate bit from_w-1 of v into every bit above it.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                               input int                from_w);
        logic [SEXT_W-1:0] r;
        r = v;
        for (int b = 0; b < SEXT_W; b++) begin
            if (b >= from_w) begin
                r[b] = v[from_w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add_tree_reco.sv
// -----------------------------------------------------------------------------
// add_tree_reco
//   Combinational signed adder tree. Sign-extends LANES products of IN_W bits
//   to OUT_W bits and reduces them pairwise to a single OUT_W-bit sum.
//   The sum wraps modulo 2^OUT_W.
// Ports
//   prods  in   LANES*IN_W  packed signed products, lane i = [i*IN_W +: IN_W]
//   sum    out  OUT_W       two's complement sum of all lanes
// -----------------------------------------------------------------------------
module add_tree_reco
    import reco_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
) (
    input  logic [LANES*IN_W-1:0] prods,
    output logic [OUT_W-1:0]      sum
);

    // Tree is built over a power-of-two leaf count; unused leaves are zero.
    localparam int LEAVES = (LANES > 1) ? (2 ** $clog2(LANES)) : 1;
    localparam int NODES  = 2 * LEAVES - 1;

    // Heap layout: node 0 is the root, children of node k are 2k+1 and 2k+2,
    // leaves occupy LEAVES-1 .. NODES-1.
    logic [OUT_W-1:0] node [NODES];

    generate
        for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < LANES) begin : g_used
                assign node[LEAVES-1+gi] =
                    OUT_W'(sext(SEXT_W'(prods[gi*IN_W +: IN_W]), IN_W));
            end else begin : g_pad
                assign node[LEAVES-1+gi] = '0;
            end
        end

        for (genvar gi = 0; gi < LEAVES - 1; gi++) begin : g_node
            assign node[gi] = node[2*gi+1] + node[2*gi+2];
        end
    endgenerate

    assign sum = node[0];

endmodule

// File: rtl/dot_reco_stage.sv
// -----------------------------------------------------------------------------
// dot_reco_stage
//   Streaming dot-product stage. A vector of VEC_LEN signed feature/weight
//   pairs arrives as VEC_LEN/LANES beats of LANES pairs. Each beat is
//   multiplied lane-wise (stage P1), reduced by an adder tree and accumulated
//   (stage P2). When the last beat of a vector leaves P2 the vector sum is
//   loaded into the output register and offered on a valid/ready handshake.
//   A result is visible two cycles after its last beat is accepted; vectors
//   stream back to back without bubbles.
// Ports
//   clk        in   1                    rising-edge clock
//   rst        in   1                    synchronous reset, active low
//   in_valid   in   1                    beat present on in_x / in_w
//   in_ready   out  1                    stage accepts a beat this cycle
//   in_x       in   LANES*inputBitwidth  signed features, lane i at [i*iw +: iw]
//   in_w       in   LANES*inputBitwidth  signed weights, same packing
//   out_valid  out  1                    data_out holds a completed vector sum
//   out_ready  in   1                    consumer takes data_out this cycle
//   data_out   out  bitwidth             signed dot product (wraps mod 2^bitwidth)
// -----------------------------------------------------------------------------
module dot_reco_stage
    import reco_pkg::*;
#(
    parameter int bitwidth      = BITWIDTH_DEF,
    parameter int inputBitwidth = INPUT_BITWIDTH_DEF,
    parameter int LANES         = LANES_DEF,
    parameter int VEC_LEN       = VEC_LEN_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*inputBitwidth-1:0] in_x,
    input  logic [LANES*inputBitwidth-1:0] in_w,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [bitwidth-1:0]            data_out
);

    localparam int N_BEATS   = beats_of(VEC_LEN, LANES);
    localparam int PROD_BITS = prod_w_of(inputBitwidth);
    localparam int CNT_W     = cnt_w_of(N_BEATS);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

    // Handshake / control
    logic                       stall;
    logic                       accept;
    logic                       first_beat;
    logic                       last_beat;
    logic [CNT_W-1:0]           beat_cnt_reg;

    // P1: registered lane products with their position tags
    logic [LANES*PROD_BITS-1:0] prod_flat;
    logic [LANES*PROD_BITS-1:0] p1_prod_reg;
    logic                       p1_valid_reg;
    logic                       p1_first_reg;
    logic                       p1_last_reg;

    // P2: reduction, accumulation and output register
    logic [bitwidth-1:0]        beat_sum;
    logic [bitwidth-1:0]        vec_sum_next;
    logic [bitwidth-1:0]        acc_reg;
    logic [bitwidth-1:0]        data_out_reg;
    logic                       out_valid_reg;
    logic                       load_result;

    // A held result that the consumer is not taking freezes the whole pipe.
    // in_ready is deliberately combinational so a take and a new beat can
    // happen on the same edge.
    assign stall    = out_valid_reg && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    assign first_beat = (beat_cnt_reg == '0);
    assign last_beat  = (beat_cnt_reg == LAST_CNT);

    // ------------------------------------------------------------------
    // Lane multipliers: signed iw x iw -> 2*iw, full precision.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
            logic signed [inputBitwidth-1:0] x_lane;
            logic signed [inputBitwidth-1:0] w_lane;
            logic signed [PROD_BITS-1:0]     p_lane;

            assign x_lane = in_x[gi*inputBitwidth +: inputBitwidth];
            assign w_lane = in_w[gi*inputBitwidth +: inputBitwidth];
            assign p_lane = x_lane * w_lane;
            assign prod_flat[gi*PROD_BITS +: PROD_BITS] = p_lane;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reduction of the P1 products to one beat sum.
    // ------------------------------------------------------------------
    add_tree_reco #(
        .LANES (LANES),
        .IN_W  (PROD_BITS),
        .OUT_W (bitwidth)
    ) u_add_tree (
        .prods (p1_prod_reg),
        .sum   (beat_sum)
    );

    // The first beat of a vector starts a fresh sum instead of adding to acc,
    // so acc never has to be cleared between vectors on the critical path.
    assign vec_sum_next = p1_first_reg ? beat_sum : (acc_reg + beat_sum);

    assign load_result = !stall && p1_valid_reg && p1_last_reg;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt_reg  <= '0;
            p1_prod_reg   <= '0;
            p1_valid_reg  <= 1'b0;
            p1_first_reg  <= 1'b0;
            p1_last_reg   <= 1'b0;
            acc_reg       <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            // Beat position only advances on accepted beats, so idle cycles
            // inside a vector leave the count where it is.
            if (accept) begin
                beat_cnt_reg <= last_beat ? '0 : (beat_cnt_reg + CNT_W'(1));
            end

            if (!stall) begin
                p1_valid_reg <= accept;
                if (accept) begin
                    p1_prod_reg  <= prod_flat;
                    p1_first_reg <= first_beat;
                    p1_last_reg  <= last_beat;
                end

                if (p1_valid_reg) begin
                    acc_reg <= p1_last_reg ? '0 : vec_sum_next;
                end
            end

            // A new result may load on the same edge the old one is taken,
            // in which case out_valid simply stays high.
            if (load_result) begin
                data_out_reg  <= vec_sum_next;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign data_out  = data_out_reg;

endmodule

// File: tb/tb_dot_reco_stage.sv
// -----------------------------------------------------------------------------
// tb_dot_reco_stage
//   Self-checking bench for dot_reco_stage with the default parameters
//   (bitwidth=32, inputBitwidth=16, LANES=4, VEC_LEN=16, 4 beats per vector).
//   Every cycle the bench drives inputs on the falling edge, lets them settle,
//   then looks at the handshake that the next rising edge will perform.
//   Accepted beats feed a reference model that computes each vector's dot
//   product with plain integer arithmetic; taken outputs are compared against
//   the model's queue of expected sums.
// -----------------------------------------------------------------------------
module tb_dot_reco_stage;

    localparam int BW    = 32;
    localparam int IW    = 16;
    localparam int LN    = 4;
    localparam int VL    = 16;
    localparam int NB    = VL / LN;
    localparam int DW    = LN * IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic [DW-1:0] in_w;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] data_out;

    dot_reco_stage #(
        .bitwidth      (BW),
        .inputBitwidth (IW),
        .LANES         (LN),
        .VEC_LEN       (VL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_txn = 0;

    typedef struct {
        logic [31:0] data;
        int          done;
    } res_t;

    res_t        exp_q[$];
    int          m_beat   = 0;
    logic [31:0] m_sum    = '0;
    bit          free_run = 1'b0;
    bit          dir_en   = 1'b0;
    logic [31:0] dir_val  = '0;
    bit          hold_vld = 1'b0;
    logic [31:0] hold_dat = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Reference: dot product of one beat, integer arithmetic, wraps at 32 bits.
    function automatic logic [31:0] beat_dot(input logic [DW-1:0] xv,
                                             input logic [DW-1:0] wv);
        int s;
        s = 0;
        for (int i = 0; i < LN; i++) begin
            s += int'($signed(xv[i*IW +: IW])) * int'($signed(wv[i*IW +: IW]));
        end
        return 32'(s);
    endfunction

    // One clock cycle: drive, settle, observe the coming handshake, update model.
    task automatic step(input logic r, input logic iv, input logic [DW-1:0] xv,
                        input logic [DW-1:0] wv, input logic ordy,
                        output bit acc_o);
        res_t e;
        acc_o = 1'b0;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_x      = xv;
        in_w      = wv;
        out_ready = ordy;
        #1;
        cyc++;
        if (!r) begin
            // Reset drops everything in flight.
            exp_q.delete();
            m_beat   = 0;
            m_sum    = '0;
            hold_vld = 1'b0;
            return;
        end

        check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});

        if (hold_vld) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", data_out, hold_dat);
        end

        if (out_valid && out_ready) begin
            n_txn++;
            $display("txn %0d: cycle %0d data_out=0x%08h (%0d)", n_txn, cyc,
                     data_out, $signed(data_out));
            if (exp_q.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", data_out, e.data);
                if (free_run) check("latency", 32'(cyc - e.done), 32'd2);
                if (dir_en)   check("directed", data_out, dir_val);
            end
        end
        hold_vld = out_valid && !out_ready;
        hold_dat = data_out;

        if (iv && in_ready) begin
            acc_o = 1'b1;
            m_sum = m_sum + beat_dot(xv, wv);
            m_beat++;
            if (m_beat == NB) begin
                e.data = m_sum;
                e.done = cyc;
                exp_q.push_back(e);
                m_beat = 0;
                m_sum  = '0;
            end
        end
    endtask

    // Beat contents: 0 random, 1 x=1/w=2, 2 x=-3/w=5, 3 x=w=0x7FFF.
    task automatic make_beat(input int mode, output logic [DW-1:0] xv,
                             output logic [DW-1:0] wv);
        for (int i = 0; i < LN; i++) begin
            case (mode)
                1:       begin xv[i*IW +: IW] = 16'd1;    wv[i*IW +: IW] = 16'd2;    end
                2:       begin xv[i*IW +: IW] = 16'hFFFD; wv[i*IW +: IW] = 16'd5;    end
                3:       begin xv[i*IW +: IW] = 16'h7FFF; wv[i*IW +: IW] = 16'h7FFF; end
                default: begin xv[i*IW +: IW] = 16'($urandom); wv[i*IW +: IW] = 16'($urandom); end
            endcase
        end
    endtask

    // Push n beats. gap: 0 continuous, 1 alternate valid, 2 random gaps.
    // ordy_mode: 0 always ready, 1 random, 2 not ready on cycles 5..10, 3 never.
    task automatic run_beats(input int n, input int mode, input int gap,
                             input int ordy_mode);
        logic [DW-1:0] xv, wv;
        logic          iv, ordy;
        bit            a;
        int            done  = 0;
        int            guard = 0;
        make_beat(mode, xv, wv);
        while (done < n && guard < 2000) begin
            case (gap)
                1:       iv = (guard % 2 == 0);
                2:       iv = ($urandom_range(0, 2) != 0);
                default: iv = 1'b1;
            endcase
            case (ordy_mode)
                1:       ordy = ($urandom_range(0, 2) != 0);
                2:       ordy = !(guard >= 5 && guard <= 10);
                3:       ordy = 1'b0;
                default: ordy = 1'b1;
            endcase
            step(1'b1, iv, xv, wv, ordy, a);
            if (a) begin
                done++;
                make_beat(mode, xv, wv);
            end
            guard++;
        end
        check("beats_accepted", 32'(done), 32'(n));
    endtask

    task automatic idle(input int n, input logic ordy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, ordy, a);
    endtask

    task automatic do_reset(input int n);
        bit a;
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, a);
    endtask

    initial begin
        bit a;
        rst = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b1;

        // Reset with in_valid high: outputs cleared, nothing emerges later.
        do_reset(3);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        idle(6, 1'b1);

        // Single vector of ones/twos, then signed values.
        free_run = 1'b1;
        dir_en = 1'b1; dir_val = 32'd32;
        run_beats(NB, 1, 0, 0);
        idle(4, 1'b1);
        dir_val = 32'hFFFFFF10;
        run_beats(NB, 2, 0, 0);
        idle(4, 1'b1);
        dir_en = 1'b0;

        // Three random vectors back to back, consumer always ready.
        run_beats(3 * NB, 0, 0, 0);
        idle(4, 1'b1);
        free_run = 1'b0;

        // Backpressure while the next vector streams.
        run_beats(3 * NB, 0, 0, 2);
        idle(6, 1'b1);

        // Saturating-magnitude operands with gaps in in_valid.
        dir_en = 1'b1; dir_val = 32'hFFF00010;
        run_beats(NB, 3, 1, 0);
        idle(4, 1'b1);
        dir_en = 1'b0;

        // Random traffic with random consumer.
        run_beats(40 * NB, 0, 2, 1);
        idle(6, 1'b1);

        // Reset mid-vector: partial vector dropped.
        run_beats(NB / 2, 0, 0, 0);
        do_reset(2);
        idle(6, 1'b1);

        // Reset during a stall: pending output dropped.
        run_beats(NB, 0, 0, 3);
        idle(4, 1'b0);
        check("stall_pending", {31'd0, out_valid}, 32'd1);
        do_reset(2);
        idle(6, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 2) != 0), a);
        end
        idle(10, 1'b1);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
